pwmcap: RTL and testbench
=========================

# pwmcap

Bus-readable PWM capture block: the input-side counterpart to the color-LED PWM drivers. Samples one external pulse-width-modulated signal and measures its high time and period in i_clk cycles. Publishes the most recent complete measurement on a two-word register window. Connects to the wishbone bus through the same fastio-style glue: strobe in, data out, ack generated outside, stall tied low.

## Interface

Parameters:
- CW, 24: width of the high-time and period counters.
- NSYNC, 2: number of input synchronizer flops (minimum 2).

Ports:
- i_clk  input  1  system clock; the only clock.
- i_reset_n  input  1  reset; asynchronous assertion, active-low.
- i_stb  input  1  bus strobe, single-cycle.
- i_we  input  1  write qualifier, valid with i_stb.
- i_addr  input  1  word select: 0 = status/high, 1 = period.
- i_data  input  32  write data.
- o_data  output  32  read data, registered.
- i_pwm  input  1  asynchronous PWM input pin.
- o_int  output  1  one-cycle pulse when a new measurement is published.

## Operation

- **Input conditioning:** i_pwm passes through NSYNC flops, then one more flop for edge detect.
  - rise = sync & ~sync_d.
  - fall = ~sync & sync_d.
- **Control register (write, addr 0):**
  - bit 31 = enable.
  - bit 30 = clear; a one-cycle action that clears valid and stuck.
  - Writes to addr 1 are ignored.
- **FSM states:** DISABLED, ARM, HIGH, LOW.
  - DISABLED: counters held at 0. Entered from any state when enable = 0.
  - ARM: waiting for the first rise after enable or after a stuck event. On rise → HIGH, pcnt <= 1.
  - HIGH: pcnt increments each cycle. On fall → LOW, hlat <= pcnt.
  - LOW: pcnt increments each cycle. On rise → HIGH and publish:
    - high_r <= hlat, period_r <= pcnt;
    - valid <= 1, o_int <= 1;
    - pcnt <= 1.
- **Saturation:** pcnt stops at 2^CW-1.
  - Reaching saturation in HIGH or LOW sets stuck <= 1 and level <= sync, then moves to ARM.
  - high_r and period_r are not updated by a stuck event.
- **Read word 0:** {valid, stuck, level, enable, 4'h0, high_r zero-extended to 24}.
- **Read word 1:** {8'h0, period_r zero-extended to 24}.
  - CW > 24 is not supported.
- **Reading has no side effects.**
- **Simultaneous events:**
  - A clear write and a publish in the same cycle: publish wins, so valid = 1; stuck is still cleared.
  - A write of enable = 0 in the same cycle as a publish: the publish is dropped and the FSM goes to DISABLED.
- **Reset values:**
  - enable = 0, state DISABLED.
  - valid = stuck = level = 0.
  - high_r = period_r = 0, pcnt = hlat = 0.
  - o_data = 0, o_int = 0, synchronizer flops = 0.
- **Reset asserted mid-measurement:** all of the above return to reset values immediately; no partial measurement is ever published.

## Timing

- Pin-to-edge-detect latency: NSYNC+1 cycles.
  - Rise and fall share this latency, so measured widths are exact.
  - For a signal high H cycles and low L cycles (H, L ≥ 1): high_r = H, period_r = H+L.
- Publish: high_r, period_r, valid and o_int update on the clock edge following the detected rise.
  - o_int is high for exactly one cycle.
- o_data is registered from i_addr on every cycle with i_stb, so data is valid on the cycle after i_stb, aligned with external ack.
  - o_data holds between strobes.
- Control writes take effect on the clock edge at i_stb.
  - First rise accepted: the cycle after enable = 1.
- The first publish after enable requires one full period following the arming rise.

## Structure

- Package pwmcap_pkg:
  - FSM state encoding (2-bit enum: DISABLED, ARM, HIGH, LOW).
  - Control bit positions: EN_BIT = 31, CLR_BIT = 30.
  - Status bit positions: 31..28.
  - Address constants.
- One natural sub-module, **pwmcap_sync**: NSYNC-stage synchronizer plus edge detector; outputs sync, rise, fall.
  - Reset asynchronously to 0.
  - Reusable for the button/switch inputs.
- Top-level contents: control register, FSM, pcnt/hlat counters, result registers, bus read mux.

## Test plan

- **Basic capture:** CW = 24, enable; drive i_pwm high 3 / low 5 repeatedly.
  - Second and later publishes read word 0 = 0x9000_0003 and word 1 = 0x0000_0008.
  - o_int pulses once per 8 cycles.
- **Extremes:** high 1 / low 1 → high_r = 1, period_r = 2. High 200 / low 56 → 200 / 256.
- **Stuck:** CW = 8, hold i_pwm high 300 cycles.
  - Stuck set with level = 1 after pcnt reaches 255; word 0 bits 31..28 = 0b0111.
  - Results remain 0; the FSM returns to ARM and re-arms on the next rise.
- **Clear vs publish:** issue clear in the exact publish cycle → valid = 1, stuck = 0.
  - Issue clear one cycle later → valid = 0.
- **Disable and reset:**
  - Disable mid-HIGH: no publish follows and the counters read 0.
  - Pulse i_reset_n low mid-LOW: all outputs return to 0 asynchronously, before the next clock edge.
  - After re-enable, the first publish occurs only after a full arming period.
- **Synchronizer latency:** NSYNC = 3; verify o_int asserts NSYNC+2 cycles after the closing i_pin rise, and the values are unchanged from the NSYNC = 2 run.

Source files
------------

// File: rtl/pwmcap_pkg.sv
// Shared constants for the PWM capture block: FSM encoding, control/status bit
// positions and the two-word register window layout.
package pwmcap_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARM      = 2'd1,
      ST_HIGH     = 2'd2,
      ST_LOW      = 2'd3
   } state_e;

   localparam int EN_BIT  = 31;
   localparam int CLR_BIT = 30;

   localparam int VALID_BIT  = 31;
   localparam int STUCK_BIT  = 30;
   localparam int LEVEL_BIT  = 29;
   localparam int ENABLE_BIT = 28;

   localparam logic ADDR_STATUS = 1'b0;
   localparam logic ADDR_PERIOD = 1'b1;

   // Result fields are presented zero-extended to this width.
   localparam int WIN_W = 24;

endpackage

// File: rtl/pwmcap_sync.sv
// Multi-flop synchronizer for an asynchronous pin plus registered edge detect.
// Rise and fall share one latency, so widths measured between them are exact.
module pwmcap_sync #(
   parameter int NSYNC = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_async,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [NSYNC-1:0] chain;
   logic             sync_d;

   assign sync = chain[NSYNC-1];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         chain  <= '0;
         sync_d <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         chain  <= {chain[NSYNC-2:0], i_async};
         sync_d <= sync;
         rise   <= sync & ~sync_d;
         fall   <= ~sync & sync_d;
      end
   end

endmodule

// File: rtl/pwmcap.sv
// PWM capture: measures high time and period of i_pwm in i_clk cycles and
// publishes the last complete measurement on a two-word bus window.
//
//   state       | meaning
//   ST_DISABLED | enable low, counters held at zero
//   ST_ARM      | waiting for the first rise (after enable or a stuck event)
//   ST_HIGH     | input high, pcnt running, fall latches high time
//   ST_LOW      | input low, pcnt running, rise publishes the measurement
module pwmcap
   import pwmcap_pkg::*;
#(
   parameter int CW    = 24,
   parameter int NSYNC = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stb,
   input  logic        i_we,
   input  logic        i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_data,
   input  logic        i_pwm,
   output logic        o_int
);

   localparam logic [CW-1:0] PMAX = '1;

   state_e        state;
   logic          enable, valid, stuck, level;
   logic [CW-1:0] pcnt, hlat, high_r, period_r;
   logic          sync, rise, fall;
   logic          wr_ctl, clr, en_nxt, sat, publish;
   logic [31:0]   status_word;
   logic          unused_data;

   pwmcap_sync #(.NSYNC(NSYNC)) u_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_async   (i_pwm),
      .sync      (sync),
      .rise      (rise),
      .fall      (fall)
   );

   assign wr_ctl      = i_stb & i_we & (i_addr == ADDR_STATUS);
   assign clr         = wr_ctl & i_data[CLR_BIT];
   // The FSM follows the enable value being written this cycle, so a disable
   // coinciding with a closing rise suppresses that publish.
   assign en_nxt      = wr_ctl ? i_data[EN_BIT] : enable;
   assign sat         = ((state == ST_HIGH) || (state == ST_LOW)) && (pcnt == PMAX);
   assign publish     = en_nxt && (state == ST_LOW) && rise && !sat;
   assign unused_data = ^i_data[29:0];

   assign status_word = {valid, stuck, level, enable, 4'h0, WIN_W'(high_r)};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         enable <= 1'b0;
      end else if (wr_ctl) begin
         enable <= i_data[EN_BIT];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_DISABLED;
         pcnt  <= '0;
         hlat  <= '0;
      end else if (!en_nxt) begin
         state <= ST_DISABLED;
         pcnt  <= '0;
         hlat  <= '0;
      end else begin
         case (state)
            ST_DISABLED: state <= ST_ARM;
            ST_ARM: begin
               if (rise) begin
                  state <= ST_HIGH;
                  pcnt  <= CW'(1);
               end
            end
            ST_HIGH: begin
               if (sat) begin
                  state <= ST_ARM;
               end else begin
                  pcnt <= pcnt + CW'(1);
                  if (fall) begin
                     state <= ST_LOW;
                     hlat  <= pcnt;
                  end
               end
            end
            ST_LOW: begin
               if (sat) begin
                  state <= ST_ARM;
               end else if (rise) begin
                  state <= ST_HIGH;
                  pcnt  <= CW'(1);
               end else begin
                  pcnt <= pcnt + CW'(1);
               end
            end
            default: state <= ST_DISABLED;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid    <= 1'b0;
         stuck    <= 1'b0;
         level    <= 1'b0;
         high_r   <= '0;
         period_r <= '0;
         o_int    <= 1'b0;
      end else begin
         o_int <= publish;
         if (publish) begin
            valid    <= 1'b1;
            high_r   <= hlat;
            period_r <= pcnt;
         end else if (clr) begin
            valid <= 1'b0;
         end
         if (en_nxt && sat) begin
            stuck <= 1'b1;
            level <= sync;
         end else if (clr) begin
            stuck <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data <= '0;
      end else if (i_stb) begin
         o_data <= (i_addr == ADDR_PERIOD) ? {8'h00, WIN_W'(period_r)} : status_word;
      end
   end

endmodule

// File: tb/tb_pwmcap.sv
// Randomized capture bench for pwmcap: three instances (CW 24/NSYNC 2,
// CW 8/NSYNC 2, CW 24/NSYNC 3) checked against a pulse-list reference model.
module tb_pwmcap;

   typedef struct {
      int h;
      int p;
   } meas_t;

   logic        clk = 1'b0;
   logic        rst_n, stb, we, addr;
   logic [31:0] wdata;
   logic        pwm_a, pwm_8;
   logic [31:0] rd_a, rd_8, rd_3;
   logic        int_a, int_8, int_3;

   int     n_chk = 0;
   int     n_pass = 0;
   int     cyc = 0;
   int     cnt_a = 0, cnt_8 = 0, cnt_3 = 0;
   bit     prev_a = 1'b0;
   bit     mon_en = 1'b0;
   bit     armed = 1'b0;
   int     ph = 0, pl = 0;
   int     last_int_cyc = -1;
   meas_t  q[$];
   meas_t  last_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pwmcap #(.CW(24), .NSYNC(2)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_we(we), .i_addr(addr),
      .i_data(wdata), .o_data(rd_a), .i_pwm(pwm_a), .o_int(int_a));

   pwmcap #(.CW(8), .NSYNC(2)) dut8 (
      .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_we(we), .i_addr(addr),
      .i_data(wdata), .o_data(rd_8), .i_pwm(pwm_8), .o_int(int_8));

   pwmcap #(.CW(24), .NSYNC(3)) dut3 (
      .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_we(we), .i_addr(addr),
      .i_data(wdata), .o_data(rd_3), .i_pwm(pwm_a), .o_int(int_3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic rd(input logic a);
      @(negedge clk); stb = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); #1; stb = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d);
      @(negedge clk); stb = 1'b1; we = 1'b1; addr = 1'b0; wdata = d;
      @(posedge clk); #1; stb = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference: each rise after the arming one publishes the previous pulse.
   task automatic pulse_a(input int h, input int l);
      if (armed) begin
         q.push_back('{ph, ph + pl});
         last_exp = '{ph, ph + pl};
      end
      armed = 1'b1; ph = h; pl = l;
      pwm_a = 1'b1; idle(h);
      pwm_a = 1'b0; idle(l);
   endtask

   task automatic pulse_8(input int h, input int l);
      pwm_8 = 1'b1; idle(h);
      pwm_8 = 1'b0; idle(l);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (int_a) begin
            chk("int_a_width", {31'b0, prev_a}, 32'd0);
            cnt_a++;
         end
         if (int_8) cnt_8++;
         if (int_3) cnt_3++;
         prev_a = int_a;
      end
   end

   initial begin
      meas_t e;
      forever begin
         @(posedge clk); #1;
         if (mon_en && int_a) begin
            chk("int_expected", {31'b0, (q.size() > 0)}, 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               if (last_int_cyc >= 0) chk("int_spacing", cyc - last_int_cyc, e.p);
               last_int_cyc = cyc;
               @(negedge clk); stb = 1'b1; we = 1'b0; addr = 1'b0;
               @(posedge clk); #1;
               chk("word0", rd_a, {8'h90, 24'(e.h)});
               addr = 1'b1;
               @(posedge clk); #1;
               chk("word1", rd_a, 32'(e.p));
               stb = 1'b0;
            end
         end
      end
   end

   initial begin
      int c0, c1, cf, lat_a, lat_3, na, n8, h, l;
      rst_n = 1'b1; stb = 1'b0; we = 1'b0; addr = 1'b0; wdata = '0;
      pwm_a = 1'b0; pwm_8 = 1'b0;
      #2 rst_n = 1'b0;
      idle(2);
      chk("rst_rd_a", rd_a, 0);
      chk("rst_rd_8", rd_8, 0);
      chk("rst_int_a", {31'b0, int_a}, 0);
      @(negedge clk); rst_n = 1'b1;
      idle(1);
      rd(1'b0); chk("rst_w0", rd_a, 0);
      rd(1'b1); chk("rst_w1", rd_a, 0);

      wr(32'h8000_0000);
      mon_en = 1'b1;
      repeat (5) pulse_a(3, 5);
      for (int i = 0; i < 30; i++) begin
         h = $urandom_range(1, 24);
         l = $urandom_range(2, 24);
         pulse_a(h, l);
      end
      idle(30);
      chk("queue_drained", q.size(), 0);
      mon_en = 1'b0;

      rd(1'b0);
      chk("nsync2_w0", rd_a, {8'h90, 24'(last_exp.h)});
      chk("nsync3_w0", rd_3, {8'h90, 24'(last_exp.h)});
      rd(1'b1);
      chk("nsync2_w1", rd_a, 32'(last_exp.p));
      chk("nsync3_w1", rd_3, 32'(last_exp.p));
      chk("nsync3_int_count", cnt_3, cnt_a);

      // o_int appears NSYNC+2 edges after the edge at which the pin rose.
      lat_a = -1; lat_3 = -1;
      c0 = cyc; pwm_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         idle(1);
         if (int_a && lat_a < 0) lat_a = cyc - c0;
         if (int_3 && lat_3 < 0) lat_3 = cyc - c0;
      end
      chk("lat_nsync2", lat_a, 4);
      chk("lat_nsync3", lat_3, 5);
      pwm_a = 1'b0; idle(5);

      n8 = cnt_8; pwm_8 = 1'b1;
      idle(300);
      chk("stuck_no_int", cnt_8 - n8, 0);
      rd(1'b0); chk("stuck_w0", rd_8, 32'h7000_0000);
      rd(1'b1); chk("stuck_w1", rd_8, 0);
      pwm_8 = 1'b0; idle(5);
      n8 = cnt_8;
      repeat (3) pulse_8(3, 5);
      chk("rearm_int_count", cnt_8 - n8, 2);

      c0 = cyc; pwm_8 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); stb = 1'b1; we = 1'b1; addr = 1'b0; wdata = 32'hC000_0000;
      @(posedge clk); #1; stb = 1'b0; we = 1'b0;
      chk("clr_pub_int", {31'b0, int_8}, 1);
      rd(1'b0); chk("clr_pub_w0", rd_8, 32'hB000_0003);
      rd(1'b1); chk("clr_pub_w1", rd_8, 8);
      cf = cyc; pwm_8 = 1'b0;
      idle(3);
      c1 = cyc; pwm_8 = 1'b1;
      idle(4);
      chk("clr_late_int", {31'b0, int_8}, 1);
      wr(32'hC000_0000);
      rd(1'b0); chk("clr_late_w0", rd_8, {8'h30, 24'(cf - c0)});
      rd(1'b1); chk("clr_late_w1", rd_8, 32'(c1 - c0));
      pwm_8 = 1'b0;

      pwm_a = 1'b1; idle(10);
      na = cnt_a;
      wr(32'h0000_0000);
      idle(5); pwm_a = 1'b0; idle(5); pwm_a = 1'b1; idle(10); pwm_a = 1'b0; idle(5);
      chk("dis_no_int", cnt_a - na, 0);
      rd(1'b0); chk("dis_status", {28'b0, rd_a[31:28]}, 32'h8);

      wr(32'h8000_0000);
      pwm_a = 1'b1; idle(4); pwm_a = 1'b0; idle(3);
      @(negedge clk); #2 rst_n = 1'b0; #1;
      chk("arst_rd_a", rd_a, 0);
      chk("arst_rd_8", rd_8, 0);
      chk("arst_rd_3", rd_3, 0);
      chk("arst_int_a", {31'b0, int_a}, 0);
      @(negedge clk); rst_n = 1'b1;
      armed = 1'b0; q.delete(); last_int_cyc = -1;
      idle(1);
      wr(32'h8000_0000);
      mon_en = 1'b1;
      na = cnt_a;
      pulse_a(4, 6);
      chk("rearm_first_no_int", cnt_a - na, 0);
      repeat (3) pulse_a(4, 6);
      idle(20);
      chk("queue_drained2", q.size(), 0);
      chk("post_rst_pubs", cnt_a - na, 3);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
